// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the HH:MM:SS time counter: mode encodings, digit
//   positions inside the packed 24-bit BCD bus, field moduli and the edit
//   masks shown to the 7-segment encoder while a field is being set.
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2
    } mode_e;

    // Digit positions in the packed digits bus (each digit is 4 bits wide).
    localparam int DIG_SEC_ONES = 0;
    localparam int DIG_SEC_TENS = 1;
    localparam int DIG_MIN_ONES = 2;
    localparam int DIG_MIN_TENS = 3;
    localparam int DIG_HR_ONES  = 4;
    localparam int DIG_HR_TENS  = 5;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HR_MOD  = 24;

    localparam logic [5:0] EDIT_MASK_NONE = 6'b000000;
    localparam logic [5:0] EDIT_MASK_HR   = 6'b110000;
    localparam logic [5:0] EDIT_MASK_MIN  = 6'b001100;

    function automatic logic [5:0] edit_mask_of(input mode_e m);
        case (m)
            MODE_SET_H: return EDIT_MASK_HR;
            MODE_SET_M: return EDIT_MASK_MIN;
            default:    return EDIT_MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clock_time_counter_bcd.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter that counts 0..MOD-1 and wraps to 00.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-low reset (clears to 00)
//     inc   in   advance by one on this edge
//     clr   in   force 00 on this edge (wins over inc)
//     tens  out  registered tens digit
//     ones  out  registered ones digit
//     wrap  out  combinational carry: inc while the value is MOD-1
// -----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    localparam logic [3:0] MAX_TENS = 4'((MOD - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MOD - 1) % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign wrap   = inc && at_max;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = '0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
//   24-hour HH:MM:SS timekeeper feeding the 6-digit 7-segment encoder.
//   A prescaler produces one tick per TICK_CYCLES clocks while running; two
//   debounced buttons select and increment the hour/minute fields.
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     btn_mode   in   one-cycle pulse: RUN -> SET_H -> SET_M -> RUN
//     btn_inc    in   one-cycle pulse: increment the field under edit
//     digits     out  packed BCD time, digit 0 (sec ones) in [3:0]
//     edit_mask  out  one bit per digit, 1 = digit under edit
//     sec_tick   out  high for the cycle showing a newly advanced second
//     mode       out  current mode (0 RUN, 1 SET_H, 2 SET_M)
// -----------------------------------------------------------------------------
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [23:0] digits,
    output logic [5:0]  edit_mask,
    output logic        sec_tick,
    output logic [1:0]  mode
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sec_tick_q;
    logic [5:0]       edit_mask_q;

    logic in_run, in_set_h, in_set_m;
    logic tick, inc_edit;
    logic sec_inc, sec_clr, min_inc, hr_inc;
    logic sec_wrap, min_wrap, hr_wrap;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;

    assign in_run   = (state_q == MODE_RUN);
    assign in_set_h = (state_q == MODE_SET_H);
    assign in_set_m = (state_q == MODE_SET_M);

    // A tick is decided purely by the prescaler; a btn_mode on the same edge
    // still lets that last second land before editing starts.
    assign tick     = in_run && (cnt_q == CNT_MAX);
    // A simultaneous mode press takes priority over an increment.
    assign inc_edit = btn_inc && !btn_mode;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_RUN:   if (btn_mode) state_d = MODE_SET_H;
            MODE_SET_H: if (btn_mode) state_d = MODE_SET_M;
            MODE_SET_M: if (btn_mode) state_d = MODE_RUN;
            default:    state_d = MODE_RUN;
        endcase
    end

    // Prescaler only runs while staying in RUN; leaving or being outside RUN
    // parks it at 0 so the first second after editing is a full one.
    always_comb begin
        cnt_d = '0;
        if (in_run && !btn_mode) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Carry chain is only live in RUN; in SET states the edited field
    // increments alone and its wrap is deliberately not forwarded.
    assign sec_inc = tick;
    assign sec_clr = in_set_m && btn_mode;
    assign min_inc = (in_run && sec_wrap) || (in_set_m && inc_edit);
    assign hr_inc  = (in_run && min_wrap) || (in_set_h && inc_edit);

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .clr  (sec_clr),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .clr  (1'b0),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap)
    );

    bcd_mod_counter #(.MOD(HR_MOD)) u_hr (
        .clk  (clk),
        .rst  (rst),
        .inc  (hr_inc),
        .clr  (1'b0),
        .tens (hr_tens),
        .ones (hr_ones),
        .wrap (hr_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MODE_RUN;
            cnt_q       <= '0;
            sec_tick_q  <= 1'b0;
            edit_mask_q <= EDIT_MASK_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sec_tick_q  <= tick;
            edit_mask_q <= edit_mask_of(state_d);
        end
    end

    always_comb begin
        digits                        = '0;
        digits[DIG_SEC_ONES*4 +: 4] = sec_ones;
        digits[DIG_SEC_TENS*4 +: 4] = sec_tens;
        digits[DIG_MIN_ONES*4 +: 4] = min_ones;
        digits[DIG_MIN_TENS*4 +: 4] = min_tens;
        digits[DIG_HR_ONES*4  +: 4] = hr_ones;
        digits[DIG_HR_TENS*4  +: 4] = hr_tens;
    end

    assign edit_mask = edit_mask_q;
    assign sec_tick  = sec_tick_q;
    assign mode      = state_q;

    // The hour wrap has no consumer: midnight simply rolls to 00.
    logic unused_hr_wrap;
    assign unused_hr_wrap = hr_wrap;

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

    localparam int TICK = 4;
    localparam int DAY  = 86400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [23:0] digits;
    logic [5:0]  edit_mask;
    logic        sec_tick;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    clock_time_counter #(.TICK_CYCLES(TICK), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .digits    (digits),
        .edit_mask (edit_mask),
        .sec_tick  (sec_tick),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: time as seconds-of-day ----------------
    int m_t    = 0;  // seconds since midnight
    int m_p    = 0;  // clocks elapsed in the current second
    int m_mode = 0;
    bit m_tick = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t = 0; m_p = 0; m_mode = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            case (m_mode)
                0: begin
                    if (m_p == TICK - 1) begin
                        m_p = 0; m_t = (m_t + 1) % DAY; m_tick = 1;
                    end else begin
                        m_p++;
                    end
                    if (btn_mode) begin m_mode = 1; m_p = 0; end
                end
                1: begin
                    if (btn_mode) m_mode = 2;
                    else if (btn_inc) m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
                end
                default: begin
                    if (btn_mode) begin
                        m_mode = 0; m_t = m_t - m_t % 60; m_p = 0;
                    end else if (btn_inc) begin
                        int mm;
                        mm = (m_t / 60) % 60;
                        m_t = m_t - mm * 60 + ((mm + 1) % 60) * 60;
                    end
                end
            endcase
        end
    end

    function automatic logic [23:0] bcd_of(input int t);
        int h, mi, s;
        h = t / 3600; mi = (t / 60) % 60; s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [5:0] mask_of(input int md);
        return (md == 1) ? 6'b110000 : (md == 2) ? 6'b001100 : 6'b000000;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_digits", digits, bcd_of(m_t));
            check("model_mask", edit_mask, mask_of(m_mode));
            check("model_tick", sec_tick, m_tick);
            check("model_mode", mode, m_mode);
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic cyc(input bit m, input bit i);
        btn_mode = m; btn_inc = i;
        @(posedge clk);
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    int ticks;

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset_digits", digits, 24'h000000);
        check("reset_mode", mode, 2'd0);
        check("reset_mask", edit_mask, 6'b0);
        check("reset_tick", sec_tick, 1'b0);
        rst = 1'b1;

        // 1. first tick after TICK edges
        repeat (3) cyc(0, 0);
        check("t1_no_early_tick", sec_tick, 1'b0);
        cyc(0, 0);
        check("t1_first_sec", digits, 24'h000001);
        check("t1_first_tick", sec_tick, 1'b1);
        cyc(0, 0);
        check("t1_tick_one_cycle", sec_tick, 1'b0);
        repeat (11) cyc(0, 0);
        check("t1_four_sec", digits, 24'h000004);

        // 2. preload 23:59 and run across midnight
        cyc(1, 0);
        repeat (23) cyc(0, 1);
        cyc(1, 0);
        repeat (59) cyc(0, 1);
        cyc(1, 0);
        check("t2_preload", digits, 24'h235900);
        repeat (58 * TICK) cyc(0, 0);
        check("t2_235958", digits, 24'h235958);
        repeat (TICK) cyc(0, 0);
        check("t2_235959", digits, 24'h235959);
        check("t2_tick_a", sec_tick, 1'b1);
        repeat (TICK) cyc(0, 0);
        check("t2_midnight", digits, 24'h000000);
        check("t2_tick_b", sec_tick, 1'b1);

        // 3. hour edit wraps, no ticks while editing
        cyc(1, 0);
        check("t3_mode", mode, 2'd1);
        check("t3_mask", edit_mask, 6'b110000);
        repeat (23) cyc(0, 1);
        check("t3_hour23", digits, 24'h230000);
        cyc(0, 1);
        check("t3_hour_wrap", digits, 24'h000000);
        ticks = 0;
        repeat (100) begin
            cyc(0, 0);
            if (sec_tick) ticks++;
        end
        check("t3_no_ticks", ticks, 0);
        check("t3_frozen", digits, 24'h000000);
        repeat (5) cyc(0, 1);
        check("t3_hour05", digits, 24'h050000);

        // 4. minute wrap without carry, clean restart
        cyc(1, 0);
        check("t4_mode", mode, 2'd2);
        check("t4_mask", edit_mask, 6'b001100);
        repeat (59) cyc(0, 1);
        check("t4_min59", digits, 24'h055900);
        cyc(0, 1);
        check("t4_min_wrap", digits, 24'h050000);
        cyc(1, 0);
        check("t4_run", mode, 2'd0);
        check("t4_mask_run", edit_mask, 6'b0);
        repeat (3) cyc(0, 0);
        check("t4_no_early_tick", sec_tick, 1'b0);
        cyc(0, 0);
        check("t4_tick", sec_tick, 1'b1);
        check("t4_sec1", digits, 24'h050001);

        // 5. simultaneous buttons
        cyc(1, 0);
        cyc(1, 1);
        check("t5_mode", mode, 2'd2);
        check("t5_hour_kept", digits, 24'h050001);

        // 6. async reset mid-edit at 12:34:00
        cyc(1, 0);
        check("t6_sec_clear", digits, 24'h050000);
        cyc(1, 0);
        repeat (7) cyc(0, 1);
        cyc(1, 0);
        repeat (34) cyc(0, 1);
        check("t6_preset", digits, 24'h123400);
        check("t6_preset_mode", mode, 2'd2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_digits", digits, 24'h000000);
        check("t6_rst_mode", mode, 2'd0);
        check("t6_rst_mask", edit_mask, 6'b0);
        @(negedge clk);
        rst = 1'b1;

        // randomized phase, with rare mid-cycle resets
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(999) == 0) begin
                #1 rst = 1'b0;
                #2 rst = 1'b1;
            end
            cyc($urandom_range(15) == 0, $urandom_range(2) == 0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
